// File: rtl/datapath_pkg.sv
// Shared constants for the datapath register file and its busy scoreboard.
package datapath_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int ZERO_IDX   = 0;
endpackage

// File: rtl/busy_scoreboard.sv
// Per-register pending-write bits with issue-over-write priority and a registered population count.
module busy_scoreboard
  import datapath_pkg::*;
#(
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_issue_en,
  input  logic [ADDR_W-1:0] i_issue_addr,
  output logic [DEPTH-1:0]  o_busy,
  output logic [ADDR_W:0]   o_busy_count
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [ADDR_W:0]  r_count;
  logic [ADDR_W:0]  w_count;

  // Clear applies first so a same-cycle issue to the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    w_busy_nxt[i_wr_addr] = w_busy_nxt[i_wr_addr] & ~i_wr_en;
    w_busy_nxt[i_issue_addr] = w_busy_nxt[i_issue_addr] | i_issue_en;
    w_busy_nxt[ZERO_IDX] = w_busy_nxt[ZERO_IDX] & (ZERO_REG == 0);
    w_count = {(ADDR_W+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
    end
  end

  // Busy bits and their count update together so the count never lags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy  <= {DEPTH{1'b0}};
      r_count <= {(ADDR_W+1){1'b0}};
    end else begin
      r_busy  <= w_busy_nxt;
      r_count <= w_count;
    end
  end

  assign o_busy       = r_busy;
  assign o_busy_count = r_count;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file: two combinational read ports, one write port,
// optional write-to-read bypass and a busy scoreboard for hazard stalls.
module regfile_scoreboard
  import datapath_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic [ADDR_W-1:0] RdAddrA,
  output logic [DATA_W-1:0] RdDataA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [DATA_W-1:0] RdDataB,
  input  logic              IssueEn,
  input  logic [ADDR_W-1:0] IssueAddr,
  output logic              BusyA,
  output logic              BusyB,
  output logic [ADDR_W:0]   BusyCount
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic              w_wr_live;
  logic              w_hit_a;
  logic              w_hit_b;
  logic              w_iss_a;
  logic              w_iss_b;
  logic              w_zero_a;
  logic              w_zero_b;

  assign w_wr_live = WrEn && !((ZERO_REG != 0) && (WrAddr == ADDR_W'(ZERO_IDX)));

  // Storage array; reset clears every entry so no stale data survives.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (w_wr_live) begin
      r_mem[WrAddr] <= WrData;
    end else begin
      r_mem[WrAddr] <= r_mem[WrAddr];
    end
  end

  // Read muxing: zero register, then bypass, then stored value; bypassed data is not busy unless re-issued.
  always_comb begin
    w_zero_a = (ZERO_REG != 0) && (RdAddrA == ADDR_W'(ZERO_IDX));
    w_zero_b = (ZERO_REG != 0) && (RdAddrB == ADDR_W'(ZERO_IDX));
    w_hit_a  = (BYPASS != 0) && w_wr_live && (WrAddr == RdAddrA);
    w_hit_b  = (BYPASS != 0) && w_wr_live && (WrAddr == RdAddrB);
    w_iss_a  = IssueEn && (IssueAddr == RdAddrA);
    w_iss_b  = IssueEn && (IssueAddr == RdAddrB);
    if (w_zero_a) begin
      RdDataA = {DATA_W{1'b0}};
    end else if (w_hit_a) begin
      RdDataA = WrData;
    end else begin
      RdDataA = r_mem[RdAddrA];
    end
    if (w_zero_b) begin
      RdDataB = {DATA_W{1'b0}};
    end else if (w_hit_b) begin
      RdDataB = WrData;
    end else begin
      RdDataB = r_mem[RdAddrB];
    end
    BusyA = w_busy[RdAddrA] && !(w_hit_a && !w_iss_a);
    BusyB = w_busy[RdAddrB] && !(w_hit_b && !w_iss_b);
  end

  busy_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .i_clk        (Clk),
    .i_rst        (Rst),
    .i_wr_en      (WrEn),
    .i_wr_addr    (WrAddr),
    .i_issue_en   (IssueEn),
    .i_issue_addr (IssueAddr),
    .o_busy       (w_busy),
    .o_busy_count (BusyCount)
  );

endmodule
